// File: rtl/mix_pkg.sv
// mix_pkg: lane/state types, mix tables and the mix_stage function shared by generator, checker and bench
package mix_pkg;
  localparam int LANES = 8;
  typedef logic [31:0] lane_t;
  typedef lane_t [LANES-1:0] state_t;
  typedef enum logic [2:0] {
    K_ADD_CONST, K_CHAIN, K_ADD_SUB, K_XOR_SHL, K_SHR_MIX, K_CHAIN2, K_MULADD_A, K_MULADD_B
  } stage_kind_e;
  typedef enum logic {COMPUTE, COLLECT} fsm_e;
  localparam lane_t MUL_A [LANES] = '{32'h9E3779B1, 32'h85EBCA77, 32'hC2B2AE3D, 32'h27D4EB2F,
                                      32'h165667B1, 32'hD3A2646D, 32'hFD7046C5, 32'hB55A4F09};
  localparam lane_t ADD_A [LANES] = '{32'h00000001, 32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF,
                                      32'h0BADF00D, 32'hCAFEBABE, 32'h13579BDF, 32'h2468ACE0};
  localparam lane_t MUL_B [LANES] = '{32'h01000193, 32'h5BD1E995, 32'hCC9E2D51, 32'h1B873593,
                                      32'hE6546B65, 32'h38495AB5, 32'h7FEB352D, 32'h846CA68B};
  localparam lane_t ADD_B [LANES] = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
                                      32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};

  function automatic state_t init_state();
    state_t s;
    for (int i = 0; i < LANES; i++) s[i] = 32'(i);
    return s;
  endfunction

  // Lanes update in place, so each lane sees the already-updated lower lanes.
  function automatic state_t mix_stage(input logic [3:0] stage, input state_t s);
    state_t o;
    stage_kind_e k;
    o = s;
    k = stage_kind_e'(3'(stage >> 1));
    for (int i = 0; i < LANES; i++) begin
      logic [2:0] l;
      l = 3'(i);
      case (k)
        K_ADD_CONST: o[l] = o[l] + 32'(i);
        K_CHAIN:     o[l] = o[l] + o[l - 3'd1];
        K_ADD_SUB:   o[l] = o[l] + o[l + 3'd1] - o[l + 3'd5];
        K_XOR_SHL:   o[l] = o[l] ^ (o[l + 3'd3] << 16);
        K_SHR_MIX:   o[l] = o[l] - (o[l + 3'd2] >> 17) + (o[l + 3'd4] >> 12);
        K_CHAIN2:    o[l] = o[l] + o[l - 3'd1] - o[l - 3'd2];
        K_MULADD_A:  o[l] = o[l] * MUL_A[l] + ADD_A[l];
        default:     o[l] = o[l] * MUL_B[l] + ADD_B[l];
      endcase
    end
    return o;
  endfunction
endpackage

// File: rtl/mix_round_engine.sv
// mix_round_engine: holds the expected lane state and applies one mix stage per cycle while step is high
module mix_round_engine
  import mix_pkg::*;
#(
  parameter int ROUND_STAGES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [2:0] lane,
  output lane_t      exp_lane,
  output logic       round_done
);
  state_t exp_q, exp_d;
  logic [3:0] stage_q, stage_d;

  always_comb begin
    round_done = step && stage_q == 4'(ROUND_STAGES - 1);
    stage_d = !step ? stage_q : round_done ? 4'd0 : stage_q + 4'd1;
    exp_d = step ? mix_stage(stage_q, exp_q) : exp_q;
  end

  assign exp_lane = exp_q[lane];

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= init_state();
      stage_q <= '0;
    end else begin
      exp_q <= exp_d;
      stage_q <= stage_d;
    end
  end
endmodule

// File: rtl/mix_stream_checker.sv
// mix_stream_checker: receives 8-lane mix frames and checks each word against a locally recomputed golden state
module mix_stream_checker
  import mix_pkg::*;
#(
  parameter int ROUND_STAGES = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             frame_done,
  output logic             mismatch,
  output logic [2:0]       err_lane,
  output logic             err_sticky,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  fsm_e state_q, state_d;
  logic [2:0] lane_q, lane_d, err_lane_q, err_lane_d;
  logic in_ready_q, in_ready_d, frame_done_q, frame_done_d, mismatch_q, mismatch_d;
  logic err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
  lane_t exp_lane;
  logic round_done, accept, bad, last;

  mix_round_engine #(.ROUND_STAGES(ROUND_STAGES)) u_engine (
    .clk,
    .rst,
    .step(state_q == COMPUTE),
    .lane(lane_q),
    .exp_lane,
    .round_done
  );

  // Lane counter wraps 7 -> 0, so the next frame starts at lane 0 without an explicit clear.
  always_comb begin
    accept = in_valid && in_ready_q;
    bad = accept && in_data != exp_lane;
    last = accept && lane_q == 3'd7;
    state_d = (state_q == COMPUTE && round_done) ? COLLECT : last ? COMPUTE : state_q;
    lane_d = accept ? lane_q + 3'd1 : lane_q;
    in_ready_d = state_d == COLLECT;
    frame_done_d = last;
    mismatch_d = bad;
    err_lane_d = bad ? lane_q : err_lane_q;
    err_sticky_d = err_sticky_q || bad;
    frame_cnt_d = frame_cnt_q + CNT_W'(last);
    err_cnt_d = (bad && !(&err_cnt_q)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COMPUTE;
      lane_q <= '0;
      in_ready_q <= 1'b0;
      frame_done_q <= 1'b0;
      mismatch_q <= 1'b0;
      err_lane_q <= '0;
      err_sticky_q <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      in_ready_q <= in_ready_d;
      frame_done_q <= frame_done_d;
      mismatch_q <= mismatch_d;
      err_lane_q <= err_lane_d;
      err_sticky_q <= err_sticky_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign in_ready = in_ready_q;
  assign frame_done = frame_done_q;
  assign mismatch = mismatch_q;
  assign err_lane = err_lane_q;
  assign err_sticky = err_sticky_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt = err_cnt_q;
endmodule
